// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with decoder handshake,
// jump redirection and a sticky misaligned-jump fault.
module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instruction,
   input  logic        instr_ready,
   input  logic        jump,
   input  logic [63:0] jump_target,
   output logic [63:0] pc,
   output logic        fault
);
   typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
   state_t      r_state, w_next;
   logic [63:0] r_pc;
   logic [31:0] r_instr;
   logic        r_fault;
   logic        w_ack, w_hs, w_misal;

   assign w_ack   = (r_state == REQ) && imem_ack;
   assign w_hs    = (r_state == HOLD) && instr_ready;
   assign w_misal = jump && (jump_target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? REQ :
               w_ack             ? HOLD :
               w_hs              ? (w_misal ? FAULT : REQ) : r_state;
   end

   // FAULT leaves pc untouched so the offending instruction's address stays visible
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_instr <= 32'h0000_0013;
         r_fault <= 1'b0;
      end else begin
         if (w_ack) r_instr <= imem_rdata;
         if (w_hs && !w_misal) r_pc <= jump ? jump_target : r_pc + 64'd4;
         if (w_hs && w_misal) r_fault <= 1'b1;
      end

   assign imem_req    = (r_state == REQ);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == HOLD);
   assign instruction = r_instr;
   assign pc          = r_pc;
   assign fault       = r_fault;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus against a flag-based behavioural model of
// the fetch unit, plus hand-computed literal checks on key transactions.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        instr_ready = 1'b0;
   logic        jump = 1'b0;
   logic [63:0] jump_target = 64'h0;
   logic [63:0] pc;
   logic        fault;

   int n_pass = 0;
   int n_total = 0;

   instr_fetch #(.RESET_PC(64'h0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
      .instruction(instruction), .instr_ready(instr_ready), .jump(jump),
      .jump_target(jump_target), .pc(pc), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Model: what the fetch unit is doing, as independent flags
   bit          m_starting, m_fetching, m_holding, m_faulted;
   logic [63:0] m_pc;
   logic [31:0] m_ins;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_starting = 1; m_fetching = 0; m_holding = 0; m_faulted = 0;
         m_pc = 64'h0; m_ins = 32'h0000_0013;
      end else if (m_starting) begin
         m_starting = 0; m_fetching = 1;
      end else if (m_fetching && imem_ack) begin
         m_ins = imem_rdata; m_fetching = 0; m_holding = 1;
      end else if (m_holding && instr_ready) begin
         m_holding = 0;
         if (!jump) begin m_pc = m_pc + 64'd4; m_fetching = 1; end
         else if (jump_target[1:0] == 2'b00) begin m_pc = jump_target; m_fetching = 1; end
         else m_faulted = 1;
      end
   end

   always @(negedge clk) begin
      chk("imem_req", {63'b0, imem_req}, {63'b0, m_fetching});
      chk("instr_valid", {63'b0, instr_valid}, {63'b0, m_holding});
      chk("instruction", {32'b0, instruction}, {32'b0, m_ins});
      chk("pc", pc, m_pc);
      chk("fault", {63'b0, fault}, {63'b0, m_faulted});
      if (m_fetching) chk("imem_addr", imem_addr, m_pc);
   end

   task automatic wait_for(input bit want_req);
      int n = 0;
      while (!(want_req ? imem_req : instr_valid) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk(want_req ? "timeout_req" : "timeout_valid", 64'd0, 64'd1);
   endtask

   task automatic fetch(input int wt, input logic [31:0] data, input logic [63:0] exp_addr);
      wait_for(1);
      chk("fetch_addr", imem_addr, exp_addr);
      repeat (wt) @(negedge clk);
      imem_ack = 1'b1; imem_rdata = data;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = $urandom;
      chk("fetch_data", {32'b0, instruction}, {32'b0, data});
      chk("fetch_valid", {63'b0, instr_valid}, 64'd1);
   endtask

   task automatic hs(input int stall, input logic j, input logic [63:0] tgt);
      wait_for(0);
      instr_ready = 1'b0;
      repeat (stall) @(negedge clk);
      instr_ready = 1'b1; jump = j; jump_target = tgt;
      @(negedge clk);
      instr_ready = 1'b0; jump = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", {63'b0, imem_req}, 64'd0);
      chk("rst_instr", {32'b0, instruction}, 64'h13);
      chk("rst_pc", pc, 64'h0);
      chk("rst_fault", {63'b0, fault}, 64'd0);
      rst_n = 1'b1; imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("idle_ack_ignored", {32'b0, instruction}, 64'h13);
      for (int i = 0; i < 4; i++) begin
         fetch(0, 32'hDEAD_0000 + i, 64'(i * 4));
         hs(0, 1'b0, 64'h0);
      end
      fetch(3, 32'h1111_2222, 64'h10);
      hs(2, 1'b0, 64'h0);
      jump = 1'b1; jump_target = 64'h200;
      fetch(2, 32'h3333_4444, 64'h14);
      hs(1, 1'b1, 64'h100);
      fetch(0, 32'h5555_6666, 64'h100);
      hs(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      fetch(0, 32'h7777_8888, 64'hFFFF_FFFF_FFFF_FFFC);
      hs(0, 1'b0, 64'h0);
      wait_for(1);
      chk("wrap_addr", imem_addr, 64'h0);
      #2 rst_n = 1'b0;
      #1 chk("async_req_drop", {63'b0, imem_req}, 64'd0);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("stray_ack_ignored", {32'b0, instruction}, 64'h13);
      fetch(0, 32'h0000_0A0A, 64'h0);
      hs(0, 1'b0, 64'h0);
      fetch(0, 32'h0000_0B0B, 64'h4);
      hs(0, 1'b1, 64'h102);
      chk("misal_fault", {63'b0, fault}, 64'd1);
      chk("misal_pc", pc, 64'h4);
      imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      imem_ack = 1'b0;
      chk("fault_no_req", {63'b0, imem_req}, 64'd0);
      #2 rst_n = 1'b0;
      #1 chk("fault_cleared", {63'b0, fault}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      fetch(0, 32'h0000_0C0C, 64'h0);
      hs(0, 1'b0, 64'h0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
